// File: rtl/int_request_ctrl_if.sv
// Signal bundle between the interrupt request front end, its request sources and the
// interrupt sequencer. The controller connects through the slave modport.
interface int_request_ctrl_if;
    logic        ext_int_req;
    logic [7:0]  ext_int_vec;
    logic        int_enable;
    logic [31:0] commit_eip;
    logic        exc_pf;
    logic        exc_gp;
    logic [31:0] exc_eip;
    logic        dec_start_int;
    logic        int_clear;
    logic        addrp1;
    logic        int_pending;
    logic [7:0]  int_vector;
    logic [31:0] int_eip;
    logic        int_ack;
    logic [31:0] idt_addr;

    modport master (
        output ext_int_req, ext_int_vec, int_enable, commit_eip,
        output exc_pf, exc_gp, exc_eip,
        output dec_start_int, int_clear, addrp1,
        input  int_pending, int_vector, int_eip, int_ack, idt_addr
    );

    modport slave (
        input  ext_int_req, ext_int_vec, int_enable, commit_eip,
        input  exc_pf, exc_gp, exc_eip,
        input  dec_start_int, int_clear, addrp1,
        output int_pending, int_vector, int_eip, int_ack, idt_addr
    );
endinterface

// File: rtl/int_request_ctrl.sv
// Interrupt/exception request front end: latches page-fault and general-protection pulses,
// arbitrates them against the external interrupt and hands one request to the sequencer.
module int_request_ctrl #(
    parameter logic [31:0] IDT_BASE = 32'h0000_0000,
    parameter logic [7:0]  VEC_GP   = 8'd13,
    parameter logic [7:0]  VEC_PF   = 8'd14
) (
    input  logic             clk,
    input  logic             reset,
    int_request_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_SERVICE
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_EXT,
        SRC_PF,
        SRC_GP
    } src_t;

    state_t      state;
    state_t      state_next;
    src_t        src_q;
    src_t        win_src;

    logic        gp_sticky;
    logic        pf_sticky;
    logic [31:0] gp_eip;
    logic [31:0] pf_eip;

    logic        gp_live;
    logic        pf_live;
    logic        ext_live;
    logic [31:0] gp_eip_live;
    logic [31:0] pf_eip_live;

    logic [7:0]  win_vector;
    logic [31:0] win_eip;
    logic        retire;

    logic        pending_q;
    logic        ack_q;
    logic [7:0]  vector_q;
    logic [31:0] eip_q;

    // A pulse arriving this cycle counts as already latched so it can win immediately.
    always_comb begin
        gp_live     = gp_sticky | bus.exc_gp;
        pf_live     = pf_sticky | bus.exc_pf;
        ext_live    = bus.ext_int_req & bus.int_enable;
        gp_eip_live = bus.exc_gp ? bus.exc_eip : gp_eip;
        pf_eip_live = bus.exc_pf ? bus.exc_eip : pf_eip;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        win_src    = SRC_NONE;
        win_vector = vector_q;
        win_eip    = eip_q;
        retire     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (gp_live) begin
                    win_src    = SRC_GP;
                    win_vector = VEC_GP;
                    win_eip    = gp_eip_live;
                    state_next = ST_PEND;
                end else if (pf_live) begin
                    win_src    = SRC_PF;
                    win_vector = VEC_PF;
                    win_eip    = pf_eip_live;
                    state_next = ST_PEND;
                end else if (ext_live) begin
                    win_src    = SRC_EXT;
                    win_vector = bus.ext_int_vec;
                    win_eip    = bus.commit_eip;
                    state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (bus.dec_start_int) begin
                    state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (bus.int_clear) begin
                    retire     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // A new pulse in the retire cycle takes priority over the clear, keeping the bit set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gp_sticky <= 1'b0;
            gp_eip    <= '0;
            pf_sticky <= 1'b0;
            pf_eip    <= '0;
        end else begin
            if (bus.exc_gp) begin
                gp_sticky <= 1'b1;
                gp_eip    <= bus.exc_eip;
            end else if (retire && (src_q == SRC_GP)) begin
                gp_sticky <= 1'b0;
            end

            if (bus.exc_pf) begin
                pf_sticky <= 1'b1;
                pf_eip    <= bus.exc_eip;
            end else if (retire && (src_q == SRC_PF)) begin
                pf_sticky <= 1'b0;
            end
        end
    end

    // Request registers only change on a win, so they hold through busy states and idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q     <= SRC_NONE;
            vector_q  <= '0;
            eip_q     <= '0;
            ack_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            if (win_src != SRC_NONE) begin
                src_q    <= win_src;
                vector_q <= win_vector;
                eip_q    <= win_eip;
            end
            ack_q     <= (win_src == SRC_EXT);
            pending_q <= (state_next != ST_IDLE);
        end
    end

    assign bus.int_pending = pending_q;
    assign bus.int_ack     = ack_q;
    assign bus.int_vector  = vector_q;
    assign bus.int_eip     = eip_q;
    assign bus.idt_addr    = IDT_BASE + {21'd0, vector_q, 3'b000} + {29'd0, bus.addrp1, 2'b00};

endmodule

// File: tb/tb_int_request_ctrl.sv
// Directed bench for int_request_ctrl: stimulus is applied 1 ns after each rising edge and
// outputs are compared at that same point against hand-computed values.
module tb_int_request_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    int_request_ctrl_if bus ();

    int_request_ctrl #(
        .IDT_BASE (32'h0000_0000),
        .VEC_GP   (8'd13),
        .VEC_PF   (8'd14)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic pend, input logic [7:0] vec,
                             input logic [31:0] eip, input logic ack);
        check({tag, ".pending"}, 32'(bus.int_pending), 32'(pend));
        check({tag, ".vector"},  32'(bus.int_vector),  32'(vec));
        check({tag, ".eip"},     bus.int_eip,          eip);
        check({tag, ".ack"},     32'(bus.int_ack),     32'(ack));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walk PEND -> SERVICE -> IDLE; the pending flag must drop right after int_clear.
    task automatic serve(input string tag);
        bus.dec_start_int = 1'b1;
        step();
        bus.dec_start_int = 1'b0;
        bus.int_clear     = 1'b1;
        step();
        bus.int_clear     = 1'b0;
        check({tag, ".retired"}, 32'(bus.int_pending), 32'd0);
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        reset             = 1'b0;
        bus.ext_int_req   = 1'b0;
        bus.ext_int_vec   = 8'h00;
        bus.int_enable    = 1'b0;
        bus.commit_eip    = 32'h0;
        bus.exc_pf        = 1'b0;
        bus.exc_gp        = 1'b0;
        bus.exc_eip       = 32'h0;
        bus.dec_start_int = 1'b0;
        bus.int_clear     = 1'b0;
        bus.addrp1        = 1'b0;

        // Reset state, including the combinational IDT offset.
        step();
        step();
        check_out("reset", 1'b0, 8'h00, 32'h0, 1'b0);
        check("reset.idt0", bus.idt_addr, 32'h0000_0000);
        bus.addrp1 = 1'b1;
        #1;
        check("reset.idt1", bus.idt_addr, 32'h0000_0004);
        bus.addrp1 = 1'b0;
        step();
        reset = 1'b1;
        step();
        check_out("idle", 1'b0, 8'h00, 32'h0, 1'b0);

        // 1: external interrupt accepted with one-cycle ack.
        bus.ext_int_req = 1'b1;
        bus.ext_int_vec = 8'h20;
        bus.int_enable  = 1'b1;
        bus.commit_eip  = 32'h0000_1000;
        step();
        check_out("ext", 1'b1, 8'h20, 32'h0000_1000, 1'b1);
        bus.addrp1 = 1'b1;
        #1;
        check("ext.idt", bus.idt_addr, 32'h0000_0104);
        bus.addrp1      = 1'b0;
        bus.ext_int_req = 1'b0;
        step();
        check_out("ext.hold", 1'b1, 8'h20, 32'h0000_1000, 1'b0);
        serve("ext");
        check("ext.keepvec", 32'(bus.int_vector), 32'h20);
        step();

        // 2: masked external request never wins.
        bus.ext_int_req = 1'b1;
        bus.ext_int_vec = 8'h40;
        bus.int_enable  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("mask.pending", 32'(bus.int_pending), 32'd0);
            check("mask.ack",     32'(bus.int_ack),     32'd0);
        end
        bus.ext_int_req = 1'b0;
        bus.int_enable  = 1'b1;

        // 3: simultaneous GP and PF; GP first, PF after one idle cycle.
        bus.exc_gp  = 1'b1;
        bus.exc_pf  = 1'b1;
        bus.exc_eip = 32'h0000_2000;
        step();
        bus.exc_gp  = 1'b0;
        bus.exc_pf  = 1'b0;
        bus.exc_eip = 32'h0;
        check_out("gp", 1'b1, 8'd13, 32'h0000_2000, 1'b0);
        check("gp.idt", bus.idt_addr, 32'h0000_0068);
        serve("gp");
        step();
        check_out("pf_after_gp", 1'b1, 8'd14, 32'h0000_2000, 1'b0);
        serve("pf_after_gp");
        step();
        check("empty.pending", 32'(bus.int_pending), 32'd0);

        // 4: PF during SERVICE of an external request waits; a PF pulse in the clear cycle wins over the clear.
        bus.ext_int_req = 1'b1;
        bus.ext_int_vec = 8'h21;
        bus.commit_eip  = 32'h0000_1100;
        step();
        bus.ext_int_req = 1'b0;
        check_out("ext21", 1'b1, 8'h21, 32'h0000_1100, 1'b1);
        bus.dec_start_int = 1'b1;
        step();
        bus.dec_start_int = 1'b0;
        bus.exc_pf  = 1'b1;
        bus.exc_eip = 32'h0000_3000;
        step();
        bus.exc_pf  = 1'b0;
        check_out("busy", 1'b1, 8'h21, 32'h0000_1100, 1'b0);
        bus.int_clear = 1'b1;
        step();
        bus.int_clear = 1'b0;
        check_out("busy.clear", 1'b0, 8'h21, 32'h0000_1100, 1'b0);
        step();
        check_out("pf3000", 1'b1, 8'd14, 32'h0000_3000, 1'b0);
        bus.dec_start_int = 1'b1;
        step();
        bus.dec_start_int = 1'b0;
        bus.int_clear = 1'b1;
        bus.exc_pf    = 1'b1;
        bus.exc_eip   = 32'h0000_3100;
        step();
        bus.int_clear = 1'b0;
        bus.exc_pf    = 1'b0;
        check("repulse.retired", 32'(bus.int_pending), 32'd0);
        step();
        check_out("pf3100", 1'b1, 8'd14, 32'h0000_3100, 1'b0);
        serve("pf3100");
        step();
        check("empty2.pending", 32'(bus.int_pending), 32'd0);

        // 5: int_clear in PEND is ignored.
        bus.ext_int_req = 1'b1;
        bus.ext_int_vec = 8'h22;
        bus.commit_eip  = 32'h0000_1200;
        step();
        bus.ext_int_req = 1'b0;
        bus.int_clear   = 1'b1;
        step();
        bus.int_clear   = 1'b0;
        check_out("pendclr", 1'b1, 8'h22, 32'h0000_1200, 1'b0);
        serve("pendclr");
        step();

        // Exception beats a simultaneous external request; the held request wins afterwards.
        bus.ext_int_req = 1'b1;
        bus.ext_int_vec = 8'h30;
        bus.commit_eip  = 32'h0000_1300;
        bus.exc_pf      = 1'b1;
        bus.exc_eip     = 32'h0000_5000;
        step();
        bus.exc_pf      = 1'b0;
        check_out("prio", 1'b1, 8'd14, 32'h0000_5000, 1'b0);
        serve("prio");
        step();
        check_out("prio.ext", 1'b1, 8'h30, 32'h0000_1300, 1'b1);
        bus.ext_int_req = 1'b0;
        serve("prio.ext");
        step();

        // 6: asynchronous reset in SERVICE with a PF latched.
        bus.ext_int_req = 1'b1;
        bus.ext_int_vec = 8'h23;
        bus.commit_eip  = 32'h0000_1400;
        step();
        bus.ext_int_req   = 1'b0;
        bus.dec_start_int = 1'b1;
        step();
        bus.dec_start_int = 1'b0;
        bus.exc_pf  = 1'b1;
        bus.exc_eip = 32'h0000_4000;
        step();
        bus.exc_pf  = 1'b0;
        check_out("svc23", 1'b1, 8'h23, 32'h0000_1400, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_out("async", 1'b0, 8'h00, 32'h0, 1'b0);
        check("async.idt", bus.idt_addr, 32'h0000_0000);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("postrst.pending", 32'(bus.int_pending), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
